// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared word width, FSM state and word type for wide_add_seq
package wide_add_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} wide_add_state_t;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/prefix_adder.sv
// prefix_adder: 32-bit Kogge-Stone adder; ports a, b, cin in, s, cout out
module prefix_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic [5:0][31:0] g;
    logic [5:0][31:0] p;
    logic [31:0]      c;
    assign g[0] = a & b;
    assign p[0] = a ^ b;
    for (genvar k = 0; k < 5; k++) begin : g_lvl
        for (genvar i = 0; i < 32; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_mrg
                assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
                assign p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
            end else begin : g_pass
                assign g[k+1][i] = g[k][i];
                assign p[k+1][i] = p[k][i];
            end
        end
    end
    assign c    = {g[5][30:0] | (p[5][30:0] & {31{cin}}), cin};
    assign s    = p[0] ^ c;
    assign cout = g[5][31] | (p[5][31] & cin);
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: WIDTH-bit add (LSW first) time-shared over one 32-bit prefix_adder; ports: clk, reset, in_valid/in_ready/a/b/cin, out_valid/out_ready/sum/cout, busy; optional op_sub via WIDE_ADD_SEQ_SUB_EN
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter  int NWORDS = 4,
    localparam int WIDTH  = WORD_W * NWORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);
    wide_add_state_t state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d, cout_q, cout_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    word_t           b_word, s_w;
    logic            c_w;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic            sub_q, sub_d;
    assign b_word = b_q[WORD_W-1:0] ^ {WORD_W{sub_q}};
`else
    assign b_word = b_q[WORD_W-1:0];
`endif
    prefix_adder u_add (
        .a   (a_q[WORD_W-1:0]),
        .b   (b_word),
        .cin (carry_q),
        .s   (s_w),
        .cout(c_w)
    );
    // a_q doubles as the result shift register: each sum word enters at the
    // top as the consumed operand word leaves at the bottom.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                idx_d   = '0;
                state_d = RUN;
`ifdef WIDE_ADD_SEQ_SUB_EN
                sub_d   = op_sub;
                carry_d = cin | op_sub;
`endif
            end
            RUN: begin
                a_d     = {s_w, a_q[WIDTH-1:WORD_W]};
                b_d     = {word_t'(0), b_q[WIDTH-1:WORD_W]};
                carry_d = c_w;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    sum_d   = a_d;
                    cout_d  = c_w;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
`ifdef WIDE_ADD_SEQ_SUB_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sub_q <= 1'b0;
        else       sub_q <= sub_d;
    end
`endif
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule
